segment_memory_input_banked: RTL
================================

Name: segment_memory_input_banked

Overview:
Parametrised successor to the per-segment input-vector store in the SpMV merge datapath. It holds NUM_BINS BRAM banks that share one write address. Up to NUM_BINS words are written per cycle, one per bank, under a lane mask. One word is read per cycle, selected by bin and segment address. Unlike the previous generation, it resolves same-cycle read/write address collisions internally by write-first forwarding, supports a stall that freezes the read pipeline without losing data, and emits an explicit read-valid.

Parameters:
DATA_WIDTH, 32, width of one input-vector word
NUM_BINS, 4, number of banks and write lanes; power of two, at least 1
BITS_ADDR_SEG, 9, word address width within one bank; depth is 2^BITS_ADDR_SEG
OUT_PIPE, 1, extra output register stage (0 or 1)
BITS_BIN (derived), log2(NUM_BINS), or 0 when NUM_BINS = 1

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
wr_en  in  1  write strobe
wr_addr  in  BITS_ADDR_SEG  write address, shared by all banks
wr_lane_mask  in  NUM_BINS  per-bank write enable, qualified by wr_en
wr_data  in  NUM_BINS x DATA_WIDTH  lane i data goes to bank i
rd_en  in  1  read request
rd_addr  in  BITS_BIN+BITS_ADDR_SEG  upper bits select the bin, lower bits the word
stall  in  1  freeze the read pipeline
rd_data  out  DATA_WIDTH  read result
rd_valid  out  1  rd_data carries a newly completed read
fwd_hit  out  1  status: the current rd_valid result was forwarded from a write

Behaviour:
- Reset, asynchronous on rst_b low:
  - rd_data, rd_valid and fwd_hit go to 0.
  - Pipeline valid flags and the forwarding capture registers clear.
  - Memory contents are not reset.
- Write:
  - Bank i is written at wr_addr with wr_data[i] when wr_en and wr_lane_mask[i] are both 1.
  - Writes are always accepted. They are independent of stall and rd_en.
- Read accept:
  - acc = rd_en & !stall.
  - rd_en while stall = 1 is dropped. The requester must hold it.
  - Only the selected bank's read enable is asserted.
- Stage S1 (cycle after acc):
  - S1 = bank output, or forwarded data on a collision.
  - s1_valid is set for one cycle per accepted read.
- Collision:
  - Occurs when acc, wr_en and wr_lane_mask[bin] are all 1 and wr_addr equals the rd_addr word address.
  - S1 returns wr_data[bin] (write-first) and fwd_hit follows along with the result.
  - If the mask bit for that bin is 0, the read returns the old memory content with no forwarding.
- Write at cycle t+1 to an address read at cycle t: the read returns the old data. There is no retroactive update.
- Stall while S1 or the output stage is valid:
  - All pipeline stages hold their value and valid.
  - No bank read is issued, so bank q is stable. S1 also keeps its own capture register, so no held data depends on the BRAM.
- Latency:
  - OUT_PIPE = 0: rd_valid asserts 1 cycle after acc.
  - OUT_PIPE = 1: rd_valid asserts 2 cycles after acc.
  - Stall cycles add to latency 1:1.
- rd_valid:
  - Pulses for exactly one cycle per accepted read in a non-stalled cycle.
  - While stalled, rd_valid and rd_data hold. The consumer samples on rd_valid & !stall.
- rd_data holds its last value when rd_valid = 0.
- Throughput: one read per cycle sustained, with back-to-back reads to any bins.
- NUM_BINS = 1: no bin bits in rd_addr, and bin 0 is always selected.
- Reset asserted mid-read: the in-flight read is discarded and rd_valid does not assert for it.

Test Plan:
- NUM_BINS=4, OUT_PIPE=1. Write addr 5 with lanes {A0,A1,A2,A3}, mask 1111. Then read bin 2 addr 5 -> rd_data = A2 with rd_valid exactly 2 cycles after acc, fwd_hit = 0.
- Same cycle: write addr 7, data B2, mask 0100, and read bin 2 addr 7 -> rd_data = B2, fwd_hit = 1. Repeat with mask 0000 -> old value, fwd_hit = 0.
- Back-to-back reads of bins 0,1,2,3 at addr 5 over 4 cycles -> rd_valid high 4 consecutive cycles carrying A0..A3 in order.
- Issue a read, then stall = 1 for 3 cycles on the cycle it is in S1 -> rd_data/rd_valid hold, result delivered exactly once after release, total latency 2+3.
- rd_en with stall = 1 -> no rd_valid ever for it. Write with stall = 1 -> data later read back correctly.
- Assert rst_b low one cycle after acc -> rd_valid = 0, rd_data = 0 immediately (asynchronous), no valid pulse after release. Memory still returns prior writes.

Source files
------------

// File: rtl/segment_memory_input_banked.sv
// Banked input-vector store: NUM_BINS BRAM banks share one write address and are
// written in parallel under a lane mask; one word is read per cycle, with write-first forwarding.
module segment_memory_input_banked #(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_BINS      = 4,
    parameter int BITS_ADDR_SEG = 9,
    parameter int OUT_PIPE      = 1,
    localparam int BITS_BIN     = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 0
) (
    input  logic                                 clk,
    input  logic                                 rst_b,
    input  logic                                 wr_en,
    input  logic [BITS_ADDR_SEG-1:0]             wr_addr,
    input  logic [NUM_BINS-1:0]                  wr_lane_mask,
    input  logic [NUM_BINS-1:0][DATA_WIDTH-1:0]  wr_data,
    input  logic                                 rd_en,
    input  logic [BITS_BIN+BITS_ADDR_SEG-1:0]    rd_addr,
    input  logic                                 stall,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 rd_valid,
    output logic                                 fwd_hit
);
    localparam int BIN_W = (BITS_BIN > 0) ? BITS_BIN : 1;
    localparam int DEPTH = 1 << BITS_ADDR_SEG;

    logic                               acc;
    logic                               collision;
    logic [BIN_W-1:0]                   rd_bin;
    logic [BITS_ADDR_SEG-1:0]           rd_word;
    logic [NUM_BINS-1:0][DATA_WIDTH-1:0] bank_q;

    assign acc     = rd_en & ~stall;
    assign rd_word = rd_addr[BITS_ADDR_SEG-1:0];

    generate
        if (NUM_BINS > 1) begin : g_bin
            assign rd_bin = rd_addr[BITS_BIN+BITS_ADDR_SEG-1:BITS_ADDR_SEG];
        end else begin : g_nobin
            assign rd_bin = '0;
        end
    endgenerate

    // The bank itself is read-before-write; write-first semantics come from this bypass.
    assign collision = wr_en & wr_lane_mask[rd_bin] & (wr_addr == rd_word);

    generate
        for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [DATA_WIDTH-1:0] q_reg;

            always_ff @(posedge clk) begin
                if (wr_en && wr_lane_mask[gi])
                    mem[wr_addr] <= wr_data[gi];
                if (acc && rd_bin == BIN_W'(gi))
                    q_reg <= mem[rd_word];
            end

            assign bank_q[gi] = q_reg;
        end
    endgenerate

    logic                  s1_valid_reg;
    logic [BIN_W-1:0]      s1_bin_reg;
    logic                  s1_fwd_reg;
    logic [DATA_WIDTH-1:0] s1_fwd_data_reg;
    logic [DATA_WIDTH-1:0] s1_cap_reg;
    logic                  s1_capd_reg;
    logic [DATA_WIDTH-1:0] s1_data;

    assign s1_data = s1_capd_reg ? s1_cap_reg :
                     s1_fwd_reg  ? s1_fwd_data_reg : bank_q[s1_bin_reg];

    // On the first stalled cycle S1 snapshots its result so a held read never leans on bank q.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1_valid_reg    <= 1'b0;
            s1_bin_reg      <= '0;
            s1_fwd_reg      <= 1'b0;
            s1_fwd_data_reg <= '0;
            s1_cap_reg      <= '0;
            s1_capd_reg     <= 1'b0;
        end else if (stall) begin
            if (s1_valid_reg && !s1_capd_reg) begin
                s1_cap_reg  <= s1_data;
                s1_capd_reg <= 1'b1;
            end
        end else begin
            s1_valid_reg <= acc;
            s1_capd_reg  <= 1'b0;
            if (acc) begin
                s1_bin_reg      <= rd_bin;
                s1_fwd_reg      <= collision;
                s1_fwd_data_reg <= wr_data[rd_bin];
            end
        end
    end

    generate
        if (OUT_PIPE != 0) begin : g_out_reg
            logic                  out_valid_reg;
            logic [DATA_WIDTH-1:0] out_data_reg;
            logic                  out_fwd_reg;

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    out_valid_reg <= 1'b0;
                    out_data_reg  <= '0;
                    out_fwd_reg   <= 1'b0;
                end else if (!stall) begin
                    out_valid_reg <= s1_valid_reg;
                    if (s1_valid_reg) begin
                        out_data_reg <= s1_data;
                        out_fwd_reg  <= s1_fwd_reg;
                    end
                end
            end

            assign rd_valid = out_valid_reg;
            assign rd_data  = out_data_reg;
            assign fwd_hit  = out_fwd_reg;
        end else begin : g_out_comb
            // Remembers the last delivered result so rd_data is stable between reads.
            logic [DATA_WIDTH-1:0] hold_data_reg;
            logic                  hold_fwd_reg;

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    hold_data_reg <= '0;
                    hold_fwd_reg  <= 1'b0;
                end else if (!stall && s1_valid_reg) begin
                    hold_data_reg <= s1_data;
                    hold_fwd_reg  <= s1_fwd_reg;
                end
            end

            assign rd_valid = s1_valid_reg;
            assign rd_data  = s1_valid_reg ? s1_data : hold_data_reg;
            assign fwd_hit  = s1_valid_reg ? s1_fwd_reg : hold_fwd_reg;
        end
    endgenerate

endmodule
